// File: rtl/vx_dram_arb_pkg.sv
// Shared sizing helpers for the DRAM arbiter, so the cluster derives the same
// requester-index and DRAM tag widths as the arbiter.
package vx_dram_arb_pkg;

   function automatic int req_sel_bits(input int num_reqs);
      return (num_reqs > 1) ? $clog2(num_reqs) : 1;
   endfunction

   // The requester index sits in the tag LSBs, below the cache's own tag.
   function automatic int tag_out_width(input int tag_in_width, input int num_reqs);
      return tag_in_width + req_sel_bits(num_reqs);
   endfunction

endpackage

// File: rtl/vx_dram_arb_rr_arbiter.sv
// Round-robin arbiter: the scan starts at rr_ptr. The pointer moves to
// winner+1 only when a grant is actually taken (enable with any request).
module vx_dram_arb_rr_arbiter
   import vx_dram_arb_pkg::*;
#(
   parameter int NUM_REQS = 2,
   localparam int SEL_BITS = req_sel_bits(NUM_REQS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [NUM_REQS-1:0] requests,
   output logic [SEL_BITS-1:0] grant_index,
   output logic [NUM_REQS-1:0] grant_onehot
);

   localparam logic [SEL_BITS:0] NUM_W = (SEL_BITS+1)'(NUM_REQS);
   localparam logic [SEL_BITS:0] ONE_W = (SEL_BITS+1)'(1);

   logic [SEL_BITS-1:0] rr_ptr_q, rr_ptr_d;
   logic [SEL_BITS:0]   cand;
   logic [SEL_BITS:0]   offset;
   logic [SEL_BITS:0]   next_ptr;
   logic                found;

   // The sum is one bit wider so that the mod-NUM_REQS wrap also works for a
   // NUM_REQS that is not a power of two.
   always_comb begin
      found        = 1'b0;
      grant_index  = rr_ptr_q;
      offset       = '0;
      cand         = '0;
      for (int k = 0; k < NUM_REQS; k++) begin
         cand = {1'b0, rr_ptr_q} + offset;
         if (cand >= NUM_W) begin
            cand = cand - NUM_W;
         end
         if (!found && requests[cand[SEL_BITS-1:0]]) begin
            found       = 1'b1;
            grant_index = cand[SEL_BITS-1:0];
         end
         offset = offset + ONE_W;
      end
      grant_onehot = found ? (NUM_REQS'(1) << grant_index) : '0;
      next_ptr = {1'b0, grant_index} + ONE_W;
      if (next_ptr >= NUM_W) begin
         next_ptr = '0;
      end
      rr_ptr_d = (enable && found) ? next_ptr[SEL_BITS-1:0] : rr_ptr_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: rtl/vx_dram_arb.sv
// Shares one DRAM port among NUM_REQS cache masters. It has a round-robin grant
// into a one-entry output register and routes responses by tag. Optional perf
// counters are enabled with VX_DRAM_ARB_PERF_EN.
module vx_dram_arb
   import vx_dram_arb_pkg::*;
#(
   parameter int NUM_REQS      = 2,
   parameter int ADDR_WIDTH    = 26,
   parameter int DATA_WIDTH    = 128,
   parameter int TAG_IN_WIDTH  = 8,
   localparam int REQ_SEL_BITS  = req_sel_bits(NUM_REQS),
   localparam int TAG_OUT_WIDTH = tag_out_width(TAG_IN_WIDTH, NUM_REQS),
   localparam int BE_WIDTH      = DATA_WIDTH / 8
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_REQS-1:0]                in_req_valid,
   input  logic [NUM_REQS-1:0]                in_req_rw,
   input  logic [NUM_REQS*BE_WIDTH-1:0]       in_req_byteen,
   input  logic [NUM_REQS*ADDR_WIDTH-1:0]     in_req_addr,
   input  logic [NUM_REQS*DATA_WIDTH-1:0]     in_req_data,
   input  logic [NUM_REQS*TAG_IN_WIDTH-1:0]   in_req_tag,
   output logic [NUM_REQS-1:0]                in_req_ready,
   output logic                               out_req_valid,
   output logic                               out_req_rw,
   output logic [BE_WIDTH-1:0]                out_req_byteen,
   output logic [ADDR_WIDTH-1:0]              out_req_addr,
   output logic [DATA_WIDTH-1:0]              out_req_data,
   output logic [TAG_OUT_WIDTH-1:0]           out_req_tag,
   input  logic                               out_req_ready,
   input  logic                               out_rsp_valid,
   input  logic [DATA_WIDTH-1:0]              out_rsp_data,
   input  logic [TAG_OUT_WIDTH-1:0]           out_rsp_tag,
   output logic                               out_rsp_ready,
   output logic [NUM_REQS-1:0]                in_rsp_valid,
   output logic [NUM_REQS*DATA_WIDTH-1:0]     in_rsp_data,
   output logic [NUM_REQS*TAG_IN_WIDTH-1:0]   in_rsp_tag,
   input  logic [NUM_REQS-1:0]                in_rsp_ready
`ifdef VX_DRAM_ARB_PERF_EN
   ,
   output logic [NUM_REQS*32-1:0]             perf_grants,
   output logic [31:0]                        perf_stalls
`endif
);

   if (NUM_REQS < 2) begin : g_bad_num_reqs
      $error("vx_dram_arb: NUM_REQS must be >= 2");
   end

   logic                     out_valid_q, out_valid_d;
   logic                     out_rw_q, out_rw_d;
   logic [BE_WIDTH-1:0]      out_byteen_q, out_byteen_d;
   logic [ADDR_WIDTH-1:0]    out_addr_q, out_addr_d;
   logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
   logic [TAG_OUT_WIDTH-1:0] out_tag_q, out_tag_d;

   logic                     can_load;
   logic                     load_en;
   logic                     accept;
   logic [REQ_SEL_BITS-1:0]  grant_idx;
   logic [NUM_REQS-1:0]      grant_onehot;
   logic [NUM_REQS-1:0]      ready_w;
   logic [REQ_SEL_BITS-1:0]  rsp_idx;
   logic                     rsp_idx_ok;
   int                       sel;

   // A grant is only offered when the output slot is free or draining this
   // cycle. This gives full throughput with a single register stage.
   assign can_load = !out_valid_q || out_req_ready;
   assign load_en  = can_load && !reset;

   vx_dram_arb_rr_arbiter #(
      .NUM_REQS     (NUM_REQS)
   ) u_rr_arbiter (
      .clk          (clk),
      .reset        (reset),
      .enable       (load_en),
      .requests     (in_req_valid),
      .grant_index  (grant_idx),
      .grant_onehot (grant_onehot)
   );

   assign ready_w      = grant_onehot & {NUM_REQS{load_en}};
   assign in_req_ready = ready_w;
   assign accept       = |ready_w;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_rw_d     = out_rw_q;
      out_byteen_d = out_byteen_q;
      out_addr_d   = out_addr_q;
      out_data_d   = out_data_q;
      out_tag_d    = out_tag_q;
      sel          = int'(grant_idx);
      if (accept) begin
         out_valid_d  = 1'b1;
         out_rw_d     = in_req_rw[grant_idx];
         out_byteen_d = in_req_byteen[sel*BE_WIDTH +: BE_WIDTH];
         out_addr_d   = in_req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
         out_data_d   = in_req_data[sel*DATA_WIDTH +: DATA_WIDTH];
         out_tag_d    = {in_req_tag[sel*TAG_IN_WIDTH +: TAG_IN_WIDTH], grant_idx};
      end else if (out_req_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      out_rw_q     <= out_rw_d;
      out_byteen_q <= out_byteen_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      out_tag_q    <= out_tag_d;
   end

   assign out_req_valid  = out_valid_q;
   assign out_req_rw     = out_rw_q;
   assign out_req_byteen = out_byteen_q;
   assign out_req_addr   = out_addr_q;
   assign out_req_data   = out_data_q;
   assign out_req_tag    = out_tag_q;

   // An index with no matching requester is accepted and dropped, so the DRAM
   // side can never deadlock on a bad tag.
   assign rsp_idx = out_rsp_tag[REQ_SEL_BITS-1:0];

   always_comb begin
      in_rsp_valid  = '0;
      out_rsp_ready = 1'b1;
      rsp_idx_ok    = 1'b0;
      for (int i = 0; i < NUM_REQS; i++) begin
         if (rsp_idx == REQ_SEL_BITS'(i)) begin
            rsp_idx_ok      = 1'b1;
            in_rsp_valid[i] = out_rsp_valid;
            out_rsp_ready   = in_rsp_ready[i];
         end
      end
   end

   assign in_rsp_data = {NUM_REQS{out_rsp_data}};
   assign in_rsp_tag  = {NUM_REQS{out_rsp_tag[TAG_OUT_WIDTH-1:REQ_SEL_BITS]}};

   a_rsp_idx_in_range : assert property (@(posedge clk) disable iff (reset)
      out_rsp_valid |-> rsp_idx_ok)
      else $error("vx_dram_arb: response tag index out of range");

`ifdef VX_DRAM_ARB_PERF_EN
   logic [31:0] perf_grants_q [NUM_REQS];
   logic [31:0] perf_grants_d [NUM_REQS];
   logic [31:0] perf_stalls_q, perf_stalls_d;

   always_comb begin
      perf_stalls_d = perf_stalls_q + 32'(out_valid_q && !out_req_ready);
      for (int i = 0; i < NUM_REQS; i++) begin
         perf_grants_d[i] = perf_grants_q[i] + 32'(ready_w[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stalls_q <= '0;
         for (int i = 0; i < NUM_REQS; i++) begin
            perf_grants_q[i] <= '0;
         end
      end else begin
         perf_stalls_q <= perf_stalls_d;
         for (int i = 0; i < NUM_REQS; i++) begin
            perf_grants_q[i] <= perf_grants_d[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_REQS; g++) begin : g_perf_out
      assign perf_grants[g*32 +: 32] = perf_grants_q[g];
   end
   assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_vx_dram_arb.sv
// Directed self-checking bench for vx_dram_arb: a two-requester instance covers
// most behaviour, and a three-requester instance covers round-robin wrap-around.
module tb_vx_dram_arb;

   logic clk;
   logic reset;

   logic [1:0]   in_req_valid;
   logic [1:0]   in_req_rw;
   logic [31:0]  in_req_byteen;
   logic [51:0]  in_req_addr;
   logic [255:0] in_req_data;
   logic [15:0]  in_req_tag;
   logic [1:0]   in_req_ready;
   logic         out_req_valid;
   logic         out_req_rw;
   logic [15:0]  out_req_byteen;
   logic [25:0]  out_req_addr;
   logic [127:0] out_req_data;
   logic [8:0]   out_req_tag;
   logic         out_req_ready;
   logic         out_rsp_valid;
   logic [127:0] out_rsp_data;
   logic [8:0]   out_rsp_tag;
   logic         out_rsp_ready;
   logic [1:0]   in_rsp_valid;
   logic [255:0] in_rsp_data;
   logic [15:0]  in_rsp_tag;
   logic [1:0]   in_rsp_ready;
`ifdef VX_DRAM_ARB_PERF_EN
   logic [63:0]  perf_grants;
   logic [31:0]  perf_stalls;
   logic [95:0]  perf_grants3;
   logic [31:0]  perf_stalls3;
`endif

   logic         reset3;
   logic [2:0]   in_req_valid3;
   logic [2:0]   in_req_ready3;
   logic [47:0]  in_req_byteen3;
   logic [77:0]  in_req_addr3;
   logic [383:0] in_req_data3;
   logic [23:0]  in_req_tag3;
   logic         out_req_valid3;
   logic         out_req_rw3;
   logic [15:0]  out_req_byteen3;
   logic [25:0]  out_req_addr3;
   logic [127:0] out_req_data3;
   logic [9:0]   out_req_tag3;
   logic         out_req_ready3;
   logic         out_rsp_ready3;
   logic [2:0]   in_rsp_valid3;
   logic [383:0] in_rsp_data3;
   logic [23:0]  in_rsp_tag3;

   int errors;
   int checks;

   vx_dram_arb u_dut (
      .clk            (clk),
      .reset          (reset),
      .in_req_valid   (in_req_valid),
      .in_req_rw      (in_req_rw),
      .in_req_byteen  (in_req_byteen),
      .in_req_addr    (in_req_addr),
      .in_req_data    (in_req_data),
      .in_req_tag     (in_req_tag),
      .in_req_ready   (in_req_ready),
      .out_req_valid  (out_req_valid),
      .out_req_rw     (out_req_rw),
      .out_req_byteen (out_req_byteen),
      .out_req_addr   (out_req_addr),
      .out_req_data   (out_req_data),
      .out_req_tag    (out_req_tag),
      .out_req_ready  (out_req_ready),
      .out_rsp_valid  (out_rsp_valid),
      .out_rsp_data   (out_rsp_data),
      .out_rsp_tag    (out_rsp_tag),
      .out_rsp_ready  (out_rsp_ready),
      .in_rsp_valid   (in_rsp_valid),
      .in_rsp_data    (in_rsp_data),
      .in_rsp_tag     (in_rsp_tag),
      .in_rsp_ready   (in_rsp_ready)
`ifdef VX_DRAM_ARB_PERF_EN
      ,
      .perf_grants    (perf_grants),
      .perf_stalls    (perf_stalls)
`endif
   );

   vx_dram_arb #(
      .NUM_REQS       (3)
   ) u_dut3 (
      .clk            (clk),
      .reset          (reset3),
      .in_req_valid   (in_req_valid3),
      .in_req_rw      (3'b000),
      .in_req_byteen  (in_req_byteen3),
      .in_req_addr    (in_req_addr3),
      .in_req_data    (in_req_data3),
      .in_req_tag     (in_req_tag3),
      .in_req_ready   (in_req_ready3),
      .out_req_valid  (out_req_valid3),
      .out_req_rw     (out_req_rw3),
      .out_req_byteen (out_req_byteen3),
      .out_req_addr   (out_req_addr3),
      .out_req_data   (out_req_data3),
      .out_req_tag    (out_req_tag3),
      .out_req_ready  (out_req_ready3),
      .out_rsp_valid  (1'b0),
      .out_rsp_data   (128'h0),
      .out_rsp_tag    (10'h0),
      .out_rsp_ready  (out_rsp_ready3),
      .in_rsp_valid   (in_rsp_valid3),
      .in_rsp_data    (in_rsp_data3),
      .in_rsp_tag     (in_rsp_tag3),
      .in_rsp_ready   (3'b111)
`ifdef VX_DRAM_ARB_PERF_EN
      ,
      .perf_grants    (perf_grants3),
      .perf_stalls    (perf_stalls3)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic test_reset();
      reset         = 1'b1;
      in_req_valid  = 2'b11;
      out_req_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_req_ready !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_ready: got %b expected 00", in_req_ready);
      end
      checks++;
      if (out_req_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_out_valid: got %b expected 0", out_req_valid);
      end
`ifdef VX_DRAM_ARB_PERF_EN
      checks++;
      if (perf_stalls !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_perf_stalls: got %0d expected 0", perf_stalls);
      end
`endif
      reset        = 1'b0;
      in_req_valid = 2'b00;
   endtask

   task automatic test_single();
      in_req_addr[25:0]   = 26'h100;
      in_req_tag[7:0]     = 8'h5A;
      in_req_rw[0]        = 1'b1;
      in_req_byteen[15:0] = 16'h00FF;
      in_req_data[127:0]  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
      in_req_valid        = 2'b01;
      out_req_ready       = 1'b1;
      #1;
      checks++;
      if (in_req_ready !== 2'b01) begin
         errors++;
         $display("[TB] FAIL single_ready: got %b expected 01", in_req_ready);
      end
      @(posedge clk);
      #1;
      in_req_valid = 2'b00;
      checks++;
      if (out_req_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL single_valid: got %b expected 1", out_req_valid);
      end
      checks++;
      if (out_req_addr !== 26'h100) begin
         errors++;
         $display("[TB] FAIL single_addr: got %h expected 100", out_req_addr);
      end
      checks++;
      if (out_req_tag !== 9'h0B4) begin
         errors++;
         $display("[TB] FAIL single_tag: got %h expected 0b4", out_req_tag);
      end
      checks++;
      if (out_req_rw !== 1'b1 || out_req_byteen !== 16'h00FF) begin
         errors++;
         $display("[TB] FAIL single_rw_be: got %b/%h expected 1/00ff", out_req_rw, out_req_byteen);
      end
      checks++;
      if (out_req_data !== 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D) begin
         errors++;
         $display("[TB] FAIL single_data: got %h", out_req_data);
      end
   endtask

   // The pointer was left at 1 by the single grant, so grants run 1,0,1,0.
   task automatic test_back_to_back();
      logic       exp_idx;
      logic [8:0] exp_tag;
      logic [25:0] exp_addr;
      in_req_addr[51:26] = 26'h200;
      in_req_tag[15:8]   = 8'h33;
      in_req_rw[1]       = 1'b0;
      in_req_valid       = 2'b11;
      out_req_ready      = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_idx  = (i % 2 == 0);
         exp_tag  = exp_idx ? {8'h33, 1'b1} : {8'h5A, 1'b0};
         exp_addr = exp_idx ? 26'h200 : 26'h100;
         #1;
         checks++;
         if (in_req_ready !== (2'b01 << exp_idx)) begin
            errors++;
            $display("[TB] FAIL b2b_ready[%0d]: got %b expected idx %0d", i, in_req_ready, exp_idx);
         end
         @(posedge clk);
         #1;
         checks++;
         if (out_req_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_valid[%0d]: got %b expected 1", i, out_req_valid);
         end
         checks++;
         if (out_req_tag !== exp_tag || out_req_addr !== exp_addr) begin
            errors++;
            $display("[TB] FAIL b2b_out[%0d]: got tag %h addr %h expected tag %h addr %h",
                     i, out_req_tag, out_req_addr, exp_tag, exp_addr);
         end
      end
   endtask

   task automatic test_stall();
      out_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (in_req_ready !== 2'b00) begin
            errors++;
            $display("[TB] FAIL stall_ready[%0d]: got %b expected 00", i, in_req_ready);
         end
         @(posedge clk);
         #1;
         checks++;
         if (out_req_valid !== 1'b1 || out_req_tag !== 9'h0B4 || out_req_addr !== 26'h100) begin
            errors++;
            $display("[TB] FAIL stall_hold[%0d]: got v=%b tag %h addr %h expected 1/0b4/100",
                     i, out_req_valid, out_req_tag, out_req_addr);
         end
      end
`ifdef VX_DRAM_ARB_PERF_EN
      checks++;
      if (perf_stalls !== 32'd5) begin
         errors++;
         $display("[TB] FAIL perf_stalls: got %0d expected 5", perf_stalls);
      end
      checks++;
      if (perf_grants !== {32'd2, 32'd3}) begin
         errors++;
         $display("[TB] FAIL perf_grants: got %h expected 00000002_00000003", perf_grants);
      end
`endif
      out_req_ready = 1'b1;
      #1;
      checks++;
      if (in_req_ready !== 2'b10) begin
         errors++;
         $display("[TB] FAIL release_ready: got %b expected 10", in_req_ready);
      end
      @(posedge clk);
      #1;
      in_req_valid = 2'b00;
      checks++;
      if (out_req_tag !== 9'h067) begin
         errors++;
         $display("[TB] FAIL release_tag: got %h expected 067", out_req_tag);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_req_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL drain_valid: got %b expected 0", out_req_valid);
      end
   endtask

   task automatic test_response();
      out_rsp_valid = 1'b1;
      out_rsp_tag   = 9'h0B3;
      out_rsp_data  = 128'h11112222_33334444_55556666_77778888;
      in_rsp_ready  = 2'b01;
      #1;
      checks++;
      if (in_rsp_valid !== 2'b10) begin
         errors++;
         $display("[TB] FAIL rsp_valid1: got %b expected 10", in_rsp_valid);
      end
      checks++;
      if (in_rsp_tag !== 16'h5959) begin
         errors++;
         $display("[TB] FAIL rsp_tag1: got %h expected 5959", in_rsp_tag);
      end
      checks++;
      if (out_rsp_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rsp_ready_blocked: got %b expected 0", out_rsp_ready);
      end
      checks++;
      if (in_rsp_data[255:128] !== 128'h11112222_33334444_55556666_77778888) begin
         errors++;
         $display("[TB] FAIL rsp_data: got %h", in_rsp_data[255:128]);
      end
      in_rsp_ready = 2'b10;
      #1;
      checks++;
      if (out_rsp_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rsp_ready_open: got %b expected 1", out_rsp_ready);
      end
      out_rsp_tag = 9'h0B2;
      #1;
      checks++;
      if (in_rsp_valid !== 2'b01 || out_rsp_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rsp_route0: got valid %b ready %b expected 01/0", in_rsp_valid, out_rsp_ready);
      end
      out_rsp_valid = 1'b0;
      #1;
      checks++;
      if (in_rsp_valid !== 2'b00) begin
         errors++;
         $display("[TB] FAIL rsp_idle: got %b expected 00", in_rsp_valid);
      end
      in_rsp_ready = 2'b00;
   endtask

   task automatic test_reset_mid();
      in_req_valid  = 2'b01;
      out_req_ready = 1'b1;
      @(posedge clk);
      #1;
      in_req_valid  = 2'b00;
      out_req_ready = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (out_req_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_held: got %b expected 1", out_req_valid);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_req_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_reset_valid: got %b expected 0", out_req_valid);
      end
      reset         = 1'b0;
      in_req_valid  = 2'b11;
      out_req_ready = 1'b1;
      #1;
      checks++;
      if (in_req_ready !== 2'b01) begin
         errors++;
         $display("[TB] FAIL mid_first_grant: got %b expected 01", in_req_ready);
      end
      @(posedge clk);
      #1;
      in_req_valid = 2'b00;
      checks++;
      if (out_req_tag !== 9'h0B4) begin
         errors++;
         $display("[TB] FAIL mid_first_tag: got %h expected 0b4", out_req_tag);
      end
   endtask

   // Requester 1 alone moves the pointer to 2, then all three valid must
   // wrap as 2,0,1.
   task automatic test_wrap();
      logic [1:0] exp_idx;
      logic [9:0] exp_tag;
      reset3 = 1'b1;
      @(posedge clk);
      #1;
      reset3 = 1'b0;
      in_req_valid3 = 3'b010;
      #1;
      checks++;
      if (in_req_ready3 !== 3'b010) begin
         errors++;
         $display("[TB] FAIL wrap_prep: got %b expected 010", in_req_ready3);
      end
      @(posedge clk);
      #1;
      in_req_valid3 = 3'b111;
      for (int i = 0; i < 3; i++) begin
         exp_idx = (i == 0) ? 2'd2 : ((i == 1) ? 2'd0 : 2'd1);
         exp_tag = (i == 0) ? {8'h42, 2'd2} : ((i == 1) ? {8'h40, 2'd0} : {8'h41, 2'd1});
         #1;
         checks++;
         if (in_req_ready3 !== (3'b001 << exp_idx)) begin
            errors++;
            $display("[TB] FAIL wrap_ready[%0d]: got %b expected idx %0d", i, in_req_ready3, exp_idx);
         end
         @(posedge clk);
         #1;
         checks++;
         if (out_req_tag3 !== exp_tag) begin
            errors++;
            $display("[TB] FAIL wrap_tag[%0d]: got %h expected %h", i, out_req_tag3, exp_tag);
         end
      end
      in_req_valid3 = 3'b000;
   endtask

   initial begin
      errors         = 0;
      checks         = 0;
      reset          = 1'b1;
      in_req_valid   = '0;
      in_req_rw      = '0;
      in_req_byteen  = '0;
      in_req_addr    = '0;
      in_req_data    = '0;
      in_req_tag     = '0;
      out_req_ready  = 1'b0;
      out_rsp_valid  = 1'b0;
      out_rsp_data   = '0;
      out_rsp_tag    = '0;
      in_rsp_ready   = '0;
      reset3         = 1'b1;
      in_req_valid3  = '0;
      in_req_byteen3 = '1;
      in_req_addr3   = {26'h30, 26'h20, 26'h10};
      in_req_data3   = '0;
      in_req_tag3    = {8'h42, 8'h41, 8'h40};
      out_req_ready3 = 1'b1;

      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_response();
      test_reset_mid();
      test_wrap();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vx_dram_arb.md
Name: VX_dram_arb

Overview:
- Shares one DRAM port between NUM_REQS cache-side DRAM masters (icache, dcache, later smem spill/texture).
- Sits between the per-core cache DRAM interfaces and the cluster/L2 DRAM port.
- Round-robin request arbitration behind a one-entry output register.
- Tag-based response routing: requester index is appended to the DRAM tag and stripped on return.

Parameters:
- NUM_REQS, 2, number of requesters; must be >= 2 (elaboration-time assertion).
- ADDR_WIDTH, 26, DRAM line address bits.
- DATA_WIDTH, 128, DRAM line data bits.
- TAG_IN_WIDTH, 8, per-requester DRAM tag bits.
- REQ_SEL_BITS, $clog2(NUM_REQS), derived; requester index width.
- TAG_OUT_WIDTH, TAG_IN_WIDTH+REQ_SEL_BITS, derived.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_req_valid  in  NUM_REQS  per-requester request valid
- in_req_rw  in  NUM_REQS  1 = write
- in_req_byteen  in  NUM_REQS*DATA_WIDTH/8  byte enables
- in_req_addr  in  NUM_REQS*ADDR_WIDTH  line addresses
- in_req_data  in  NUM_REQS*DATA_WIDTH  write data
- in_req_tag  in  NUM_REQS*TAG_IN_WIDTH  tags
- in_req_ready  out  NUM_REQS  per-requester accept
- out_req_valid/rw/byteen/addr/data  out  1/1/DATA_WIDTH/8/ADDR_WIDTH/DATA_WIDTH  merged request
- out_req_tag  out  TAG_OUT_WIDTH  {in_tag, req_idx}, index in LSBs
- out_req_ready  in  1  DRAM accept
- out_rsp_valid  in  1  DRAM response valid
- out_rsp_data  in  DATA_WIDTH  response data
- out_rsp_tag  in  TAG_OUT_WIDTH  response tag
- out_rsp_ready  out  1  response accept
- in_rsp_valid  out  NUM_REQS  routed response valid (one-hot or zero)
- in_rsp_data  out  NUM_REQS*DATA_WIDTH  broadcast data
- in_rsp_tag  out  NUM_REQS*TAG_IN_WIDTH  broadcast tag, index bits stripped
- in_rsp_ready  in  NUM_REQS  requester response accept

Behaviour:
- Reset:
  - out_req_valid=0.
  - RR pointer rr_ptr=0.
  - All in_req_ready=0 during the reset cycle.
  - Perf counters=0.
- Output register (one entry):
  - can_load = !out_req_valid || out_req_ready.
  - When out_req_valid && !out_req_ready, all out_req_* fields hold stable.
- Arbitration:
  - Winner = first valid index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQS.
  - in_req_ready[i] = can_load && (i==winner) && |in_req_valid; at most one ready high.
  - Ready may be asserted combinationally; requesters must not make valid depend on ready.
- Accept (in_req_valid[w] && in_req_ready[w]):
  - Register fields; out_tag = {in_req_tag[w], w}.
  - out_req_valid=1 next cycle; request latency is 1 cycle.
  - rr_ptr <= (w+1) mod NUM_REQS; wrap from NUM_REQS-1 to 0.
- Without an accept:
  - rr_ptr unchanged.
  - out_req_valid <= 0 if out_req_ready is high, otherwise holds.
- Back-to-back: simultaneous drain (out_req_ready) and new accept is allowed in the same cycle, giving full throughput.
- Response path (combinational, zero latency):
  - idx = out_rsp_tag[REQ_SEL_BITS-1:0].
  - in_rsp_valid[idx] = out_rsp_valid; all other bits 0.
  - in_rsp_tag = out_rsp_tag[TAG_OUT_WIDTH-1:REQ_SEL_BITS].
  - out_rsp_ready = in_rsp_ready[idx].
  - idx >= NUM_REQS (non-power-of-2 NUM_REQS): response is dropped with out_rsp_ready=1; simulation assertion fires.
- Reads and writes are arbitrated identically. The arbiter keeps no ordering state; ordering within one requester is preserved because grants are serialized.
- Reset mid-operation: a held output request is discarded (out_req_valid=0 next cycle); responses in flight are the DRAM side's responsibility.

Optional Feature:
- Macro: VX_DRAM_ARB_PERF_EN.
- Defined — adds output ports:
  - perf_grants  NUM_REQS*32  per-requester accept counts.
  - perf_stalls  32  cycles with out_req_valid && !out_req_ready.
  - All counters wrap modulo 2^32 and are cleared by reset.
- Undefined: ports and counters absent; functionally identical otherwise.

Decomposition:
- Shared package / VX_define.vh: REQ_SEL_BITS and TAG_OUT_WIDTH helper macros, so the cluster uses the same tag width.
- One natural sub-module: VX_rr_arbiter (NUM_REQS requests, enable input; outputs grant_index and grant_onehot; owns rr_ptr, updates only when enable && any request).

Test Plan:
- Reset then requester 0 alone, addr=0x100, tag=0x5A, out_req_ready=1 -> next cycle out_req_valid=1, addr=0x100, out_req_tag=0xB4 (NUM_REQS=2), rr_ptr=1.
- Both valid continuously, out_req_ready=1 -> grants alternate 0,1,0,1; in_req_ready one-hot every cycle; 100% output occupancy.
- Output stalled 5 cycles (out_req_ready=0) with both valid -> out_req_* stable, in_req_ready=0 throughout, perf_stalls=5 (PERF_EN).
- out_rsp_valid=1, out_rsp_tag=0x0B3, in_rsp_ready[1]=0 -> in_rsp_valid=2'b10, in_rsp_tag=0x59, out_rsp_ready=0; then ready[1]=1 -> out_rsp_ready=1.
- Reset asserted while out_req_valid=1 && out_req_ready=0 -> out_req_valid=0 next cycle; first grant after reset goes to requester 0.
- NUM_REQS=3, rr_ptr=2, all valid -> grant 2, then 0, then 1 (wrap-around).
